// File: rtl/rv_core_ctrl.sv
// ---------------------------------------------------------------------------
// rv_core_ctrl
//
// Sequencing controller for a single-cycle RV32I datapath.  Decodes the
// instruction presented by the datapath fetch stage into datapath control
// signals and runs a small state machine that decides in which cycles the
// PC may advance (pc_en) and architectural state may be written.  Handles
// multi-cycle memory operations, debug halt / resume / single-step, EBREAK,
// and sticky traps for illegal instructions and ECALL.
//
// Parameters
//   MEM_LAT  extra wait cycles per LW/SW (0..15); a memory op occupies
//            MEM_LAT+1 cycles, the last of which commits
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous reset, active low
//   Inst          current instruction from the datapath
//   dbg_halt_req  level, halt at the next instruction boundary
//   dbg_resume    pulse, leave HALT and run freely
//   dbg_step      pulse, leave HALT for exactly one instruction
//   ImmSel        immediate format 0=I 1=S 2=B 3=U 4=J
//   RegWEn        register-file write enable (commit cycles only)
//   BrUn          unsigned branch compare
//   ASel          ALU A operand 0=rs1 1=PC
//   BSel          ALU B operand 0=rs2 1=Imm
//   ALUSel        ALU operation (see ALU_* codes)
//   MemRW         store enable (commit cycles only)
//   WBSel         write-back source 0=mem 1=alu 2=pc+4
//   Branch        branch condition 0=none 1=EQ 2=NE 3=LT 4=GE
//   Jump          JAL/JALR
//   pc_en         PC advance / commit strobe
//   halted        controller is in HALT
//   trap          sticky trap flag
//   trap_cause    0=none 1=illegal 2=ECALL
//   instret       number of pc_en cycles, wraps
// ---------------------------------------------------------------------------
module rv_core_ctrl #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Inst,
    input  logic             dbg_halt_req,
    input  logic             dbg_resume,
    input  logic             dbg_step,
    output logic [2:0]       ImmSel,
    output logic             RegWEn,
    output logic             BrUn,
    output logic             ASel,
    output logic             BSel,
    output logic [4:0]       ALUSel,
    output logic             MemRW,
    output logic [1:0]       WBSel,
    output logic [2:0]       Branch,
    output logic             Jump,
    output logic             pc_en,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    // Opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ECALL   = 2'd2;

    // A memory op only leaves RUN/STEP when there is at least one wait cycle.
    localparam logic       HAS_WAIT  = (MEM_LAT > 0);
    localparam logic [3:0] WCNT_LOAD = 4'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_HALT     = 3'd3,
        S_STEP     = 3'd4,
        S_TRAP     = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             step_q, step_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic dec_regwen;
    logic dec_store;
    logic dec_mem;
    logic dec_illegal;
    logic is_ecall;
    logic is_ebreak;
    logic sys_inst;
    logic commit;

    assign opcode = Inst[6:0];
    assign funct3 = Inst[14:12];
    assign funct7 = Inst[31:25];

    // ------------------------------------------------------------------
    // Instruction decode (purely combinational, independent of state)
    // ------------------------------------------------------------------
    always_comb begin
        ImmSel      = IMM_I;
        ASel        = 1'b0;
        BSel        = 1'b0;
        ALUSel      = ALU_ADD;
        WBSel       = WB_ALU;
        Branch      = BR_NONE;
        BrUn        = 1'b0;
        Jump        = 1'b0;
        dec_regwen  = 1'b0;
        dec_store   = 1'b0;
        dec_mem     = 1'b0;
        dec_illegal = 1'b0;
        is_ecall    = 1'b0;
        is_ebreak   = 1'b0;

        case (opcode)
            OPC_LUI: begin
                ImmSel     = IMM_U;
                BSel       = 1'b1;
                ALUSel     = ALU_PASSB;
                dec_regwen = 1'b1;
            end
            OPC_AUIPC: begin
                ImmSel     = IMM_U;
                ASel       = 1'b1;
                BSel       = 1'b1;
                dec_regwen = 1'b1;
            end
            OPC_JAL: begin
                ImmSel     = IMM_J;
                ASel       = 1'b1;
                BSel       = 1'b1;
                Jump       = 1'b1;
                WBSel      = WB_PC4;
                dec_regwen = 1'b1;
            end
            OPC_JALR: begin
                ImmSel     = IMM_I;
                BSel       = 1'b1;
                Jump       = 1'b1;
                WBSel      = WB_PC4;
                dec_regwen = 1'b1;
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                ImmSel = IMM_B;
                ASel   = 1'b1;
                BSel   = 1'b1;
                case (funct3)
                    3'b000:  Branch = BR_EQ;
                    3'b001:  Branch = BR_NE;
                    3'b100:  Branch = BR_LT;
                    3'b101:  Branch = BR_GE;
                    3'b110: begin
                        Branch = BR_LT;
                        BrUn   = 1'b1;
                    end
                    3'b111: begin
                        Branch = BR_GE;
                        BrUn   = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ImmSel     = IMM_I;
                BSel       = 1'b1;
                WBSel      = WB_MEM;
                dec_regwen = 1'b1;
                dec_mem    = 1'b1;
                if (funct3 != 3'b010) dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                ImmSel    = IMM_S;
                BSel      = 1'b1;
                dec_store = 1'b1;
                dec_mem   = 1'b1;
                if (funct3 != 3'b010) dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                ImmSel     = IMM_I;
                BSel       = 1'b1;
                dec_regwen = 1'b1;
                case (funct3)
                    3'b000: ALUSel = ALU_ADD;
                    3'b010: ALUSel = ALU_SLT;
                    3'b011: ALUSel = ALU_SLTU;
                    3'b100: ALUSel = ALU_XOR;
                    3'b110: ALUSel = ALU_OR;
                    3'b111: ALUSel = ALU_AND;
                    3'b001: begin
                        // Shift-immediates reuse funct7 as an opcode extension.
                        if (funct7 == F7_BASE) ALUSel = ALU_SLL;
                        else                   dec_illegal = 1'b1;
                    end
                    default: begin
                        if      (funct7 == F7_BASE) ALUSel = ALU_SRL;
                        else if (funct7 == F7_ALT)  ALUSel = ALU_SRA;
                        else                        dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec_regwen = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ALUSel = ALU_ADD;
                        3'b001:  ALUSel = ALU_SLL;
                        3'b010:  ALUSel = ALU_SLT;
                        3'b011:  ALUSel = ALU_SLTU;
                        3'b100:  ALUSel = ALU_XOR;
                        3'b101:  ALUSel = ALU_SRL;
                        3'b110:  ALUSel = ALU_OR;
                        default: ALUSel = ALU_AND;
                    endcase
                end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
                    ALUSel = ALU_SUB;
                end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
                    ALUSel = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                // Single hart, no caches: FENCE retires as a no-op.
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                if      (Inst == INST_ECALL)  is_ecall    = 1'b1;
                else if (Inst == INST_EBREAK) is_ebreak   = 1'b1;
                else                          dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_regwen = 1'b0;
            dec_store  = 1'b0;
            dec_mem    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: next state and pc_en
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        step_d  = step_q;
        cause_d = cause_q;
        pc_en   = 1'b0;

        case (state_q)
            S_RST_HOLD: state_d = S_RUN;

            // STEP executes exactly like RUN except that it ignores halt
            // requests and always falls back to HALT afterwards.
            S_RUN, S_STEP: begin
                if ((state_q == S_RUN) && dbg_halt_req) begin
                    state_d = S_HALT;
                end else if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_ecall) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ECALL;
                end else if (is_ebreak) begin
                    pc_en   = 1'b1;
                    state_d = S_HALT;
                end else if (dec_mem && HAS_WAIT) begin
                    wcnt_d  = WCNT_LOAD;
                    step_d  = (state_q == S_STEP);
                    state_d = S_MEM_WAIT;
                end else begin
                    pc_en   = 1'b1;
                    state_d = (state_q == S_STEP) ? S_HALT : S_RUN;
                end
            end

            // A started memory op always completes; a halt request only
            // redirects where we go after the commit cycle.
            S_MEM_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    pc_en   = 1'b1;
                    state_d = (step_q || dbg_halt_req) ? S_HALT : S_RUN;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end

            S_HALT: begin
                if      (dbg_resume) state_d = S_RUN;
                else if (dbg_step)   state_d = S_STEP;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_RST_HOLD;
        endcase
    end

    // SYSTEM instructions may strobe pc_en but never write state.
    assign sys_inst = is_ecall | is_ebreak;
    assign commit   = pc_en & ~sys_inst;
    assign RegWEn   = dec_regwen & commit;
    assign MemRW    = dec_store & commit;

    assign instret_d = pc_en ? (instret_q + CNT_W'(1)) : instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RST_HOLD;
            wcnt_q    <= 4'd0;
            step_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            step_q    <= step_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign halted     = (state_q == S_HALT);
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_rv_core_ctrl.sv
`timescale 1ns/1ps
module tb_rv_core_ctrl;

    localparam int LAT = 2;
    localparam int CW  = 8;

    localparam int K_NORM  = 0;
    localparam int K_EBRK  = 1;
    localparam int K_ECALL = 2;
    localparam int K_ILL   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   Inst;
    logic          dbg_halt_req, dbg_resume, dbg_step;
    logic [2:0]    ImmSel;
    logic          RegWEn, BrUn, ASel, BSel, MemRW, Jump;
    logic [4:0]    ALUSel;
    logic [1:0]    WBSel;
    logic [2:0]    Branch;
    logic          pc_en, halted, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    rv_core_ctrl #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Inst(Inst),
        .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
        .ImmSel(ImmSel), .RegWEn(RegWEn), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
        .ALUSel(ALUSel), .MemRW(MemRW), .WBSel(WBSel), .Branch(Branch), .Jump(Jump),
        .pc_en(pc_en), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    typedef struct {
        logic [31:0] inst;
        int          kind;
        logic [2:0]  imm;
        logic        asel, bsel;
        logic [4:0]  alu;
        logic [1:0]  wb;
        logic [2:0]  br;
        logic        brun, jmp, regw, store, mem, cd;
    } vec_t;

    vec_t vecs[$];
    int   norm_idx[$], bad_idx[$], ebrk_idx[$];

    int            n_chk = 0;
    int            n_fail = 0;
    logic [CW-1:0] hc;

    // Reference model of the sequencing rules
    bit         m_first, m_halt, m_trap, m_step;
    int         m_age;
    logic [1:0] m_cause;

    function automatic vec_t mk(logic [31:0] i, int k, logic [2:0] imm, bit a, bit b,
                                logic [4:0] alu, logic [1:0] wb, logic [2:0] br, bit brun,
                                bit j, bit rw, bit st, bit mem, bit cd);
        vec_t v;
        v.inst = i; v.kind = k; v.imm = imm; v.asel = a; v.bsel = b; v.alu = alu;
        v.wb = wb; v.br = br; v.brun = brun; v.jmp = j; v.regw = rw; v.store = st;
        v.mem = mem; v.cd = cd;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ctl = {pc_en, RegWEn, MemRW, halted, trap, trap_cause}
    task automatic chk_cyc(input string name, input bit pc, input bit rw, input bit mw,
                           input bit hl, input bit tr, input logic [1:0] c);
        check({name, " ctl"}, {25'd0, pc_en, RegWEn, MemRW, halted, trap, trap_cause},
              {25'd0, pc, rw, mw, hl, tr, c});
        check({name, " instret"}, {24'd0, instret}, {24'd0, hc});
        if (pc) hc = hc + 1'b1;
    endtask

    // ImmSel only matters when the immediate is selected; WBSel only when rd is written.
    task automatic chk_dec(input string name, input vec_t v);
        check({name, " dec"},
              {15'd0, (v.bsel ? ImmSel : 3'd0), ASel, BSel, ALUSel, Branch, BrUn, Jump,
               (v.regw ? WBSel : 2'd0)},
              {15'd0, (v.bsel ? v.imm : 3'd0), v.asel, v.bsel, v.alu, v.br, v.brun, v.jmp,
               (v.regw ? v.wb : 2'd0)});
    endtask

    task automatic model_reset();
        m_first = 1'b1; m_halt = 1'b0; m_trap = 1'b0; m_step = 1'b0;
        m_age = 0; m_cause = 2'd0;
    endtask

    task automatic model_cycle(input int kind, input bit mem, input bit hreq,
                               input bit res, input bit stp, output bit pc);
        pc = 1'b0;
        if (m_first) begin
            m_first = 1'b0;
        end else if (m_trap) begin
            m_trap = 1'b1;
        end else if (m_halt) begin
            if (res) begin
                m_halt = 1'b0; m_step = 1'b0;
            end else if (stp) begin
                m_halt = 1'b0; m_step = 1'b1;
            end
        end else if (m_age > 0) begin
            if (m_age == LAT) begin
                pc = 1'b1; m_age = 0;
                if (m_step || hreq) m_halt = 1'b1;
            end else begin
                m_age++;
            end
        end else if (hreq && !m_step) begin
            m_halt = 1'b1;
        end else if (kind == K_ILL) begin
            m_trap = 1'b1; m_cause = 2'd1;
        end else if (kind == K_ECALL) begin
            m_trap = 1'b1; m_cause = 2'd2;
        end else if (kind == K_EBRK) begin
            pc = 1'b1; m_halt = 1'b1;
        end else if (mem && LAT > 0) begin
            m_age = 1;
        end else begin
            pc = 1'b1;
            if (m_step) m_halt = 1'b1;
        end
    endtask

    function automatic int pick();
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)  return bad_idx[$urandom_range(0, bad_idx.size() - 1)];
        if (r < 8)  return ebrk_idx[0];
        return norm_idx[$urandom_range(0, norm_idx.size() - 1)];
    endfunction

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    initial begin
        bit   pc, eh, et, hreq, res, stp;
        logic [1:0] ec;
        int   cur, trap_cycles;
        vec_t v;

        //                 inst          kind     imm a b alu wb br brun j rw st mem cd
        vecs.push_back(mk(I_ADDI,        K_NORM,  0, 0,1, 0, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h123450B7,  K_NORM,  3, 0,1,10, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h00001097,  K_NORM,  3, 1,1, 0, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h008000EF,  K_NORM,  4, 1,1, 0, 2, 0, 0,1, 1,0,0, 1));
        vecs.push_back(mk(32'h000100E7,  K_NORM,  0, 0,1, 0, 2, 0, 0,1, 1,0,0, 1));
        vecs.push_back(mk(32'h00208463,  K_NORM,  2, 1,1, 0, 0, 1, 0,0, 0,0,0, 1));
        vecs.push_back(mk(32'h00209463,  K_NORM,  2, 1,1, 0, 0, 2, 0,0, 0,0,0, 1));
        vecs.push_back(mk(32'h0020C463,  K_NORM,  2, 1,1, 0, 0, 3, 0,0, 0,0,0, 1));
        vecs.push_back(mk(32'h0020F463,  K_NORM,  2, 1,1, 0, 0, 4, 1,0, 0,0,0, 1));
        vecs.push_back(mk(32'h0020E463,  K_NORM,  2, 1,1, 0, 0, 3, 1,0, 0,0,0, 1));
        vecs.push_back(mk(I_LW,          K_NORM,  0, 0,1, 0, 0, 0, 0,0, 1,0,1, 1));
        vecs.push_back(mk(I_SW,          K_NORM,  1, 0,1, 0, 0, 0, 0,0, 0,1,1, 1));
        vecs.push_back(mk(32'h402081B3,  K_NORM,  0, 0,0, 1, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h4020D1B3,  K_NORM,  0, 0,0, 7, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h0020B1B3,  K_NORM,  0, 0,0, 4, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h0020F1B3,  K_NORM,  0, 0,0, 9, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h4030D093,  K_NORM,  0, 0,1, 7, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h00309093,  K_NORM,  0, 0,1, 2, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'hFFF0C093,  K_NORM,  0, 0,1, 5, 1, 0, 0,0, 1,0,0, 1));
        vecs.push_back(mk(32'h0000000F,  K_NORM,  0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(I_EBRK,        K_EBRK,  0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(I_ECALL,       K_ECALL, 0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(32'hFFFFFFFF,  K_ILL,   0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(32'h0000B103,  K_ILL,   0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(32'h022081B3,  K_ILL,   0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(32'h00209067,  K_ILL,   0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        vecs.push_back(mk(32'h00001073,  K_ILL,   0, 0,0, 0, 0, 0, 0,0, 0,0,0, 0));
        foreach (vecs[i]) begin
            if (vecs[i].kind == K_NORM)      norm_idx.push_back(i);
            else if (vecs[i].kind == K_EBRK) ebrk_idx.push_back(i);
            else                             bad_idx.push_back(i);
        end

        // Reset and first instruction
        rst = 1'b0; Inst = I_ADDI; dbg_halt_req = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
        hc = '0;
        #1;
        chk_cyc("reset", 0, 0, 0, 0, 0, 2'd0);
        cyc(); cyc();
        rst = 1'b1;
        #1; chk_cyc("rst_hold", 0, 0, 0, 0, 0, 2'd0);
        cyc();
        chk_cyc("first_addi", 1, 1, 0, 0, 0, 2'd0);
        chk_dec("first_addi", vecs[0]);
        cyc();
        check("instret_after_first", {24'd0, instret}, 32'd1);

        // Decode table; memory ops take LAT wait cycles then commit once
        foreach (vecs[i]) begin
            if (vecs[i].kind == K_NORM) begin
                v = vecs[i];
                Inst = v.inst;
                #1;
                if (v.cd) chk_dec($sformatf("vec%0d", i), v);
                if (v.mem) begin
                    for (int w = 0; w < LAT; w++) begin
                        chk_cyc($sformatf("vec%0d_wait%0d", i, w), 0, 0, 0, 0, 0, 2'd0);
                        cyc();
                    end
                end
                chk_cyc($sformatf("vec%0d_commit", i), 1, v.regw, v.store, 0, 0, 2'd0);
                cyc();
            end
        end

        // EBREAK halts after one non-writing pc_en; single-step an addi
        Inst = I_EBRK; #1; chk_cyc("ebreak", 1, 0, 0, 0, 0, 2'd0);
        cyc();
        Inst = I_ADDI; #1; chk_cyc("halt_a", 0, 0, 0, 1, 0, 2'd0);
        cyc(); #1; chk_cyc("halt_b", 0, 0, 0, 1, 0, 2'd0);
        dbg_step = 1'b1; #1; chk_cyc("halt_step_req", 0, 0, 0, 1, 0, 2'd0);
        cyc();
        dbg_step = 1'b0; #1; chk_cyc("step_addi", 1, 1, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("step_rehalt", 0, 0, 0, 1, 0, 2'd0);
        cyc();

        // Single-step a load: whole memory op, then back to HALT
        Inst = I_LW; dbg_step = 1'b1; #1; chk_cyc("steplw_req", 0, 0, 0, 1, 0, 2'd0);
        cyc();
        dbg_step = 1'b0; #1; chk_cyc("steplw_0", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("steplw_1", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("steplw_commit", 1, 1, 0, 0, 0, 2'd0);
        check("steplw_wbsel", {30'd0, WBSel}, 32'd0);
        cyc();
        Inst = I_ADDI; #1; chk_cyc("steplw_rehalt", 0, 0, 0, 1, 0, 2'd0);

        // Step ignores a pending halt request
        dbg_halt_req = 1'b1; dbg_step = 1'b1;
        cyc();
        dbg_step = 1'b0; #1; chk_cyc("step_ign_hreq", 1, 1, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("step_ign_rehalt", 0, 0, 0, 1, 0, 2'd0);
        dbg_halt_req = 1'b0;

        // Resume and step together: resume wins
        dbg_resume = 1'b1; dbg_step = 1'b1;
        cyc();
        dbg_resume = 1'b0; dbg_step = 1'b0; #1; chk_cyc("resume_win_a", 1, 1, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("resume_win_b", 1, 1, 0, 0, 0, 2'd0);
        cyc();

        // Halt request in RUN: no commit, then halted
        dbg_halt_req = 1'b1; #1; chk_cyc("hreq_run", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("hreq_halted", 0, 0, 0, 1, 0, 2'd0);
        dbg_halt_req = 1'b0; dbg_resume = 1'b1;
        cyc();
        dbg_resume = 1'b0;

        // Halt request raised mid memory op: load still commits, then halt
        Inst = I_LW; #1; chk_cyc("hmid_0", 0, 0, 0, 0, 0, 2'd0);
        cyc();
        dbg_halt_req = 1'b1; #1; chk_cyc("hmid_1", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("hmid_commit", 1, 1, 0, 0, 0, 2'd0);
        cyc();
        Inst = I_ADDI; #1; chk_cyc("hmid_halted", 0, 0, 0, 1, 0, 2'd0);
        dbg_halt_req = 1'b0; dbg_resume = 1'b1;
        cyc();
        dbg_resume = 1'b0;

        // Reset during the wait of a store: store dropped, outputs clear at once
        Inst = I_SW; #1; chk_cyc("rstsw_0", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("rstsw_1", 0, 0, 0, 0, 0, 2'd0);
        rst = 1'b0; hc = '0; #1; chk_cyc("rstsw_async", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("rstsw_held", 0, 0, 0, 0, 0, 2'd0);
        Inst = I_ADDI; rst = 1'b1; #1; chk_cyc("rstsw_hold", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("rstsw_run", 1, 1, 0, 0, 0, 2'd0);
        cyc();

        // Illegal instruction: sticky trap, debug has no effect
        Inst = 32'hFFFF_FFFF; #1; chk_cyc("ill_0", 0, 0, 0, 0, 0, 2'd0);
        cyc();
        dbg_resume = 1'b1; #1; chk_cyc("ill_trap", 0, 0, 0, 0, 1, 2'd1);
        cyc();
        dbg_resume = 1'b0; dbg_step = 1'b1; Inst = I_ADDI; #1; chk_cyc("ill_sticky1", 0, 0, 0, 0, 1, 2'd1);
        cyc();
        dbg_step = 1'b0; #1; chk_cyc("ill_sticky2", 0, 0, 0, 0, 1, 2'd1);
        rst = 1'b0; hc = '0; #1; chk_cyc("ill_reset", 0, 0, 0, 0, 0, 2'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // ECALL traps with cause 2
        Inst = I_ECALL; #1; chk_cyc("ecall_0", 0, 0, 0, 0, 0, 2'd0);
        cyc(); #1; chk_cyc("ecall_trap", 0, 0, 0, 0, 1, 2'd2);
        cyc(); #1; chk_cyc("ecall_sticky", 0, 0, 0, 0, 1, 2'd2);

        // Randomized run against the reference model
        rst = 1'b0; hc = '0; #1; chk_cyc("rand_reset", 0, 0, 0, 0, 0, 2'd0);
        model_reset();
        cyc();
        rst = 1'b1;
        hreq = 1'b0; trap_cycles = 0;
        cur = pick();
        for (int n = 0; n < 3000; n++) begin
            if (!hreq && $urandom_range(0, 19) == 0)      hreq = 1'b1;
            else if (hreq && $urandom_range(0, 3) == 0)   hreq = 1'b0;
            res = ($urandom_range(0, 5) == 0);
            stp = ($urandom_range(0, 5) == 0);
            dbg_halt_req = hreq; dbg_resume = res; dbg_step = stp;
            v = vecs[cur];
            Inst = v.inst;
            #1;
            eh = m_halt; et = m_trap; ec = m_cause;
            model_cycle(v.kind, v.mem, hreq, res, stp, pc);
            chk_cyc("rand", pc, pc & v.regw, pc & v.store, eh, et, ec);
            if (v.kind == K_NORM && v.cd) chk_dec("rand", v);
            cyc();
            if (pc) cur = pick();
            if (m_trap) trap_cycles++;
            if (trap_cycles > 3) begin
                rst = 1'b0; hc = '0; #1;
                chk_cyc("rand_trap_reset", 0, 0, 0, 0, 0, 2'd0);
                model_reset();
                cyc();
                rst = 1'b1;
                trap_cycles = 0;
                cur = pick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
